// File: rtl/rv523_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv523_pkg                                                           |
// | Shared encodings for the RV523 pipeline boundary registers.         |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
package rv523_pkg;

  // Occupancy of the skid buffer, two bits wide; 2'd3 is never legal.
  typedef logic [1:0] skidState_t;

  localparam skidState_t SKID_EMPTY = 2'd0;  // no word held
  localparam skidState_t SKID_BUSY  = 2'd1;  // head word in MAIN only
  localparam skidState_t SKID_FULL  = 2'd2;  // MAIN and SKID both occupied

endpackage
`default_nettype wire

// File: rtl/skid_pipe_reg_dff_r.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dff_r                                                               |
// | Rising-edge master-slave flop built from two complementary-enable   |
// | latches, with asynchronous active-high clear of both stages.        |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module dff_r #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] masterQ;

  // Master latch: transparent while clk is low, so it closes on the rising edge.
  always_latch begin
    if (rst) begin
      masterQ <= '0;
    end else if (!clk) begin
      masterQ <= d;
    end
  end

  // Slave latch: transparent while clk is high, presenting the value the master froze.
  always_latch begin
    if (rst) begin
      q <= '0;
    end else if (clk) begin
      q <= masterQ;
    end
  end

endmodule
`default_nettype wire

// File: rtl/skid_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | skid_pipe_reg                                                       |
// | Two-entry valid/ready skid buffer giving one fully registered,      |
// | back-pressurable boundary between RV523 pipeline stages.            |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module skid_pipe_reg
  import rv523_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady
);

  skidState_t       state;
  skidState_t       stateNext;
  logic [WIDTH-1:0] mainQ;
  logic [WIDTH-1:0] mainD;
  logic [WIDTH-1:0] skidQ;
  logic [WIDTH-1:0] skidD;
  logic             mainLoad;
  logic             mainFromSkid;
  logic             skidLoad;
  logic             inReadyD;
  logic             outValidD;
  logic             inFire;
  logic             outFire;

  // Both handshake qualifiers come from registered outputs, so neither
  // OUT_READY nor IN_* can reach the opposite side combinationally.
  assign inFire  = inValid & inReady;
  assign outFire = outValid & outReady;
  assign outData = mainQ;

  // State register.
  dff_r #(.WIDTH(2)) stateReg (
    .clk (clk),
    .rst (rst),
    .d   (stateNext),
    .q   (state)
  );

  // Next-state and load-enable decode; registers load only on the listed transitions.
  always_comb begin
    stateNext    = state;
    mainLoad     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (inFire) begin
          stateNext = SKID_BUSY;
          mainLoad  = 1'b1;
        end
      end
      SKID_BUSY: begin
        if (inFire && outFire) begin
          mainLoad = 1'b1;
        end else if (inFire) begin
          stateNext = SKID_FULL;
          skidLoad  = 1'b1;
        end else if (outFire) begin
          stateNext = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // IN_READY is low here, so only the downstream side can move.
        if (outFire) begin
          stateNext    = SKID_BUSY;
          mainLoad     = 1'b1;
          mainFromSkid = 1'b1;
        end
      end
      default: begin
        stateNext = SKID_EMPTY;
      end
    endcase
  end

  // Datapath and output-flop inputs, decoded from the upcoming state so the
  // registered handshake outputs line up with the state register.
  always_comb begin
    mainD     = mainQ;
    skidD     = skidQ;
    if (mainLoad) begin
      mainD = mainFromSkid ? skidQ : inData;
    end
    if (skidLoad) begin
      skidD = inData;
    end
    inReadyD  = (stateNext != SKID_FULL);
    outValidD = (stateNext != SKID_EMPTY);
  end

  // Head word; stale contents are kept once drained.
  dff_r #(.WIDTH(WIDTH)) mainReg (
    .clk (clk),
    .rst (rst),
    .d   (mainD),
    .q   (mainQ)
  );

  // Overflow word captured when downstream stalls.
  dff_r #(.WIDTH(WIDTH)) skidReg (
    .clk (clk),
    .rst (rst),
    .d   (skidD),
    .q   (skidQ)
  );

  // IN_READY is cleared by reset and only rises on the first edge afterwards.
  dff_r #(.WIDTH(1)) inReadyReg (
    .clk (clk),
    .rst (rst),
    .d   (inReadyD),
    .q   (inReady)
  );

  dff_r #(.WIDTH(1)) outValidReg (
    .clk (clk),
    .rst (rst),
    .d   (outValidD),
    .q   (outValid)
  );

endmodule
`default_nettype wire
